fmc_div_sequencer: RTL and testbench
====================================

// Module: fmc_div_sequencer
// PURPOSE
//  Generates the divider counter state (N_counter, M_counter, DIV_N, DIV_M) that the
//  FMC select logic consumes. Counts clk_ext cycles in N+1-cycle sub-periods grouped
//  M+1 per frame. Reprogramming uses a valid/ready config handshake, and new values
//  take effect only at a frame boundary.
// PARAMETERS
//  N_W  3  width of N / N_counter
//  M_W  2  width of M / M_counter
// PORTS
//  clk_ext    in   1    sole clock, all logic on rising edge
//  rst        in   1    synchronous, active-high reset
//  en         in   1    run enable; 0 forces IDLE
//  cfg_valid  in   1    new config offered
//  cfg_ready  out  1    config accepted when cfg_valid && cfg_ready
//  cfg_N      in   N_W  requested N (sub-period = cfg_N+1 cycles)
//  cfg_M      in   M_W  requested M (frame = cfg_M+1 sub-periods)
//  N          out  N_W  active N
//  M          out  M_W  active M
//  N_counter  out  N_W  cycle count within sub-period
//  M_counter  out  M_W  sub-period count within frame
//  DIV_N      out  1    high while N_counter==N
//  DIV_M      out  1    high while N_counter==N && M_counter==M (frame end)
//  frame_start out 1    high while N_counter==0 && M_counter==0 in RUN
// BEHAVIOUR
//  - All outputs registered; no combinational input->output paths.
//  - Reset: state=IDLE, N=0, M=0, counters=0, DIV_N=DIV_M=frame_start=0, pending empty,
//    cfg_ready=1.
//  - FSM IDLE->RUN when en=1 at the edge. RUN->IDLE when en=0 at the edge. In IDLE,
//    counters and strobes are held at 0.
//  - RUN, each edge: if N_counter==N then N_counter<=0, else N_counter+1. On N wrap:
//    if M_counter==M then M_counter<=0 (frame end), else M_counter+1.
//  - DIV_N, DIV_M and frame_start are computed from the next-state counters, so they
//    coincide with the counter values they describe. The first RUN cycle shows counters
//    0/0 with frame_start=1.
//  - N=0: DIV_N high every RUN cycle. N=0 and M=0: DIV_M high every RUN cycle.
//  - Frame length = (N+1)*(M+1) cycles. No overflow, because counters never exceed
//    N or M.
//  - Config in IDLE: accepted value is loaded into N/M at that edge.
//  - Config in RUN: accepted value goes into a one-entry pending buffer. cfg_ready=0
//    while the buffer is full. The pending value loads into N/M on the frame-end edge
//    and counters restart at 0; the buffer empties on that edge.
//  - Accept on the same edge as a frame end: that frame end uses the old (empty)
//    buffer, and the new config applies at the following frame end.
//  - en drops with a pending config: the pending value loads into N/M on the IDLE
//    entry edge.
//  - rst mid-frame: immediate return to reset values; the pending config is discarded.
// CONFIGURATION
//  FMC_SEL_GEN_EN defined: adds output sel[1:0], registered with the strobes.
//    sel=2'b01 when DIV_M, sel=2'b10 when DIV_N && !DIV_M, else 2'b00. Reset value 2'b00.
//  FMC_SEL_GEN_EN undefined: sel port and its logic are absent; the external select
//    logic decodes the counters.
// STRUCTURE
//  - fmc_pkg: state enum {IDLE, RUN}, default N_W/M_W, SEL_* code constants
//    (SEL_NONE=2'b00, SEL_M=2'b01, SEL_N=2'b10).
//  - Sub-module fmc_cfg_buffer: one-entry pending register with valid/ready handshake,
//    load strobe and flush-on-reset.
//  - Top module: FSM, counters and strobe registers.
// TESTING
//  1. rst, then en=1 with N=3, M=1: DIV_N high every 4th cycle, DIV_M every 8th,
//     frame_start on cycles 0, 8, 16.
//  2. N=0, M=0: DIV_N=DIV_M=frame_start=1 on every RUN cycle.
//  3. RUN with N=3, M=1, cfg N=1, M=2 accepted mid-frame: cfg_ready=0 until frame end,
//     then 6-cycle frames with DIV_N every 2nd cycle.
//  4. cfg accepted exactly on a DIV_M cycle: old config runs one more full frame,
//     then the new config takes effect.
//  5. en=0 mid-frame, then en=1: counters 0, frame_start=1 on the first RUN cycle.
//     rst mid-frame: all outputs return to reset values and pending is cleared.
//  6. FMC_SEL_GEN_EN, N=1, M=1: sel sequence 00,10,00,01 repeating.

Source files
------------

// File: rtl/fmc_pkg.sv
// Shared types and constants for the FMC divider sequencer.
// The select-code helper is only used when FMC_SEL_GEN_EN is defined.
package fmc_pkg;

    localparam int N_W_DEF = 3;
    localparam int M_W_DEF = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fmc_state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_M    = 2'b01;
    localparam logic [1:0] SEL_N    = 2'b10;

    // Frame end wins over a plain sub-period end.
    function automatic logic [1:0] sel_code(input logic div_n, input logic div_m);
        logic [1:0] code;
        case ({div_m, div_n})
            2'b11, 2'b10: code = SEL_M;
            2'b01:        code = SEL_N;
            default:      code = SEL_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fmc_cfg_buffer.sv
// One-entry pending configuration register with a registered ready flag.
// A write and a load can never coincide because ready is low while the entry is full.
module fmc_cfg_buffer
    import fmc_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int M_W = M_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [N_W-1:0] wr_n,
    input  logic [M_W-1:0] wr_m,
    input  logic           load,
    output logic           valid,
    output logic           ready,
    output logic [N_W-1:0] pend_n,
    output logic [M_W-1:0] pend_m
);

    logic           valid_q, valid_d;
    logic           ready_q, ready_d;
    logic [N_W-1:0] pend_n_q, pend_n_d;
    logic [M_W-1:0] pend_m_q, pend_m_d;

    // Entry capture / release.
    always_comb begin
        valid_d  = valid_q;
        pend_n_d = pend_n_q;
        pend_m_d = pend_m_q;
        if (wr_en) begin
            valid_d  = 1'b1;
            pend_n_d = wr_n;
            pend_m_d = wr_m;
        end else if (load) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        ready_d = ~valid_d;
    end

    // Buffer state register; reset flushes any pending entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            pend_n_q <= '0;
            pend_m_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            pend_n_q <= pend_n_d;
            pend_m_q <= pend_m_d;
        end
    end

    assign valid  = valid_q;
    assign ready  = ready_q;
    assign pend_n = pend_n_q;
    assign pend_m = pend_m_q;

endmodule

// File: rtl/fmc_div_sequencer.sv
// Divider counter sequencer: N+1-cycle sub-periods grouped M+1 per frame.
// Optional registered select output enabled by defining FMC_SEL_GEN_EN.
module fmc_div_sequencer
    import fmc_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int M_W = M_W_DEF
) (
    input  logic           clk_ext,
    input  logic           rst,
    input  logic           en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [N_W-1:0] cfg_N,
    input  logic [M_W-1:0] cfg_M,
    output logic [N_W-1:0] N,
    output logic [M_W-1:0] M,
    output logic [N_W-1:0] N_counter,
    output logic [M_W-1:0] M_counter,
    output logic           DIV_N,
    output logic           DIV_M,
`ifdef FMC_SEL_GEN_EN
    output logic [1:0]     sel,
`endif
    output logic           frame_start
);

    fmc_state_e     state_q, state_d;
    logic [N_W-1:0] n_q, n_d, ncnt_q, ncnt_d;
    logic [M_W-1:0] m_q, m_d, mcnt_q, mcnt_d;
    logic           div_n_q, div_n_d, div_m_q, div_m_d, fs_q, fs_d;
    logic           accept_s, load_s, frame_end_s, buf_wr_s;
    logic           pend_valid_s;
    logic [N_W-1:0] pend_n_s;
    logic [M_W-1:0] pend_m_s;

    assign accept_s    = cfg_valid & cfg_ready;
    assign frame_end_s = (ncnt_q == n_q) && (mcnt_q == m_q);
    assign buf_wr_s    = accept_s && (state_q == RUN);

    fmc_cfg_buffer #(.N_W(N_W), .M_W(M_W)) u_cfg_buffer (
        .clk    (clk_ext),
        .rst    (rst),
        .wr_en  (buf_wr_s),
        .wr_n   (cfg_N),
        .wr_m   (cfg_M),
        .load   (load_s),
        .valid  (pend_valid_s),
        .ready  (cfg_ready),
        .pend_n (pend_n_s),
        .pend_m (pend_m_s)
    );

    // Next state, counters and strobes; strobes describe the next counter values.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        ncnt_d  = '0;
        mcnt_d  = '0;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    n_d = cfg_N;
                    m_d = cfg_M;
                end else begin
                    load_s = pend_valid_s;
                end
                state_d = en ? RUN : IDLE;
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    load_s  = pend_valid_s;
                end else if (ncnt_q == n_q) begin
                    mcnt_d = (mcnt_q == m_q) ? '0 : mcnt_q + M_W'(1);
                    load_s = frame_end_s && pend_valid_s;
                end else begin
                    ncnt_d = ncnt_q + N_W'(1);
                    mcnt_d = mcnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_s) begin
            n_d = pend_n_s;
            m_d = pend_m_s;
        end else begin
            n_d = n_d;
        end
        div_n_d = (state_d == RUN) && (ncnt_d == n_d);
        div_m_d = div_n_d && (mcnt_d == m_d);
        fs_d    = (state_d == RUN) && (ncnt_d == '0) && (mcnt_d == '0);
    end

    // Sequencer state register.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            m_q     <= '0;
            ncnt_q  <= '0;
            mcnt_q  <= '0;
            div_n_q <= 1'b0;
            div_m_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            ncnt_q  <= ncnt_d;
            mcnt_q  <= mcnt_d;
            div_n_q <= div_n_d;
            div_m_q <= div_m_d;
            fs_q    <= fs_d;
        end
    end

`ifdef FMC_SEL_GEN_EN
    logic [1:0] sel_q;

    // Select code registered alongside the strobes.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            sel_q <= SEL_NONE;
        end else begin
            sel_q <= sel_code(div_n_d, div_m_d);
        end
    end

    assign sel = sel_q;
`endif

    assign N           = n_q;
    assign M           = m_q;
    assign N_counter   = ncnt_q;
    assign M_counter   = mcnt_q;
    assign DIV_N       = div_n_q;
    assign DIV_M       = div_m_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_fmc_div_sequencer.sv
// Self-checking bench for fmc_div_sequencer: vector table, directed corner sequences
// and random stimulus against a frame-position reference model.
module tb_fmc_div_sequencer;

    logic       clk_ext = 1'b0;
    logic       rst = 1'b0, en = 1'b0, cfg_valid = 1'b0;
    logic [2:0] cfg_N = 3'd0;
    logic [1:0] cfg_M = 2'd0;
    logic       cfg_ready, DIV_N, DIV_M, frame_start;
    logic [2:0] N, N_counter;
    logic [1:0] M, M_counter;
`ifdef FMC_SEL_GEN_EN
    logic [1:0] sel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_ext = ~clk_ext;

    fmc_div_sequencer dut (
        .clk_ext(clk_ext), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_N(cfg_N), .cfg_M(cfg_M), .N(N), .M(M), .N_counter(N_counter), .M_counter(M_counter),
        .DIV_N(DIV_N), .DIV_M(DIV_M),
`ifdef FMC_SEL_GEN_EN
        .sel(sel),
`endif
        .frame_start(frame_start)
    );

    // Reference model: frame position plus a pending slot.
    bit m_run = 0, m_pv = 0;
    int m_n = 0, m_m = 0, m_pos = 0, m_pn = 0, m_pm = 0;

    task automatic model_step(input bit r, input bit e, input bit v, input int cn, input int cm);
        bit acc;
        if (r) begin
            m_run = 0; m_n = 0; m_m = 0; m_pos = 0; m_pv = 0;
        end else begin
            acc = v && !m_pv;
            if (!m_run) begin
                if (acc) begin m_n = cn; m_m = cm; end
                else if (m_pv) begin m_n = m_pn; m_m = m_pm; m_pv = 0; end
                m_pos = 0;
                m_run = e;
            end else begin
                if (!e) begin
                    m_run = 0; m_pos = 0;
                    if (m_pv) begin m_n = m_pn; m_m = m_pm; m_pv = 0; end
                end else if (m_pos == (m_n + 1) * (m_m + 1) - 1) begin
                    m_pos = 0;
                    if (m_pv) begin m_n = m_pn; m_m = m_pm; m_pv = 0; end
                end else begin
                    m_pos++;
                end
                if (acc) begin m_pv = 1; m_pn = cn; m_pm = cm; end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        int nc, mc, dn, dm, fs;
        nc = m_run ? m_pos % (m_n + 1) : 0;
        mc = m_run ? m_pos / (m_n + 1) : 0;
        dn = m_run && (nc == m_n);
        dm = m_run && (m_pos == (m_n + 1) * (m_m + 1) - 1);
        fs = m_run && (m_pos == 0);
        check("model_N", N, m_n);
        check("model_M", M, m_m);
        check("model_ncnt", N_counter, nc);
        check("model_mcnt", M_counter, mc);
        check("model_div_n", DIV_N, dn);
        check("model_div_m", DIV_M, dm);
        check("model_frame_start", frame_start, fs);
        check("model_ready", cfg_ready, !m_pv);
`ifdef FMC_SEL_GEN_EN
        check("model_sel", sel, dm ? 1 : (dn ? 2 : 0));
`endif
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int cn, input int cm);
        rst = r; en = e; cfg_valid = v; cfg_N = 3'(cn); cfg_M = 2'(cm);
        @(posedge clk_ext);
        model_step(r, e, v, cn, cm);
        #1;
        cmp_model();
    endtask

    typedef struct {
        bit r, e, v;
        int cn, cm;
        int xn, xm, xnc, xmc, xdn, xdm, xfs, xrdy;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // rst, IDLE config N=3 M=1, then eight RUN cycles and drop en.
        vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 0, 1, 3, 1,  3, 1, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{0, 1, 0, 0, 0,  3, 1, 0, 0, 0, 0, 1, 1};
        vecs[3]  = '{0, 1, 0, 0, 0,  3, 1, 1, 0, 0, 0, 0, 1};
        vecs[4]  = '{0, 1, 0, 0, 0,  3, 1, 2, 0, 0, 0, 0, 1};
        vecs[5]  = '{0, 1, 0, 0, 0,  3, 1, 3, 0, 1, 0, 0, 1};
        vecs[6]  = '{0, 1, 0, 0, 0,  3, 1, 0, 1, 0, 0, 0, 1};
        vecs[7]  = '{0, 1, 0, 0, 0,  3, 1, 1, 1, 0, 0, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 0,  3, 1, 2, 1, 0, 0, 0, 1};
        vecs[9]  = '{0, 1, 0, 0, 0,  3, 1, 3, 1, 1, 1, 0, 1};
        vecs[10] = '{0, 1, 0, 0, 0,  3, 1, 0, 0, 0, 0, 1, 1};
        vecs[11] = '{0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 1};

        @(negedge clk_ext);
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].cn, vecs[i].cm);
            check("vec_N", N, vecs[i].xn);
            check("vec_M", M, vecs[i].xm);
            check("vec_ncnt", N_counter, vecs[i].xnc);
            check("vec_mcnt", M_counter, vecs[i].xmc);
            check("vec_div_n", DIV_N, vecs[i].xdn);
            check("vec_div_m", DIV_M, vecs[i].xdm);
            check("vec_frame_start", frame_start, vecs[i].xfs);
            check("vec_ready", cfg_ready, vecs[i].xrdy);
        end

        // N=0, M=0: every RUN cycle is sub-period end, frame end and frame start.
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0);
            check("n0m0_strobes", {DIV_N, DIV_M, frame_start}, 3'b111);
        end

        // Mid-frame reprogramming N=3,M=1 -> N=1,M=2 waits for frame end.
        step(0, 0, 1, 3, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 2);
        check("pend_ready_low", cfg_ready, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        check("pend_new_N", N, 1);
        check("pend_restart", frame_start, 1);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);

        // Accept on the frame-end edge: old config runs a full extra frame.
        step(0, 0, 1, 3, 1);
        begin
            int guard = 0;
            step(0, 1, 0, 0, 0);
            while (!DIV_M && guard < 20) begin step(0, 1, 0, 0, 0); guard++; end
            check("wait_div_m_bound", guard < 20, 1);
        end
        step(0, 1, 1, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
        check("fe_accept_old_N", N, 3);
        step(0, 1, 0, 0, 0);
        check("fe_accept_new_N", N, 1);
        check("fe_accept_new_M", M, 0);

        // en drop and re-entry, then rst with a pending entry.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("reenter_fs", frame_start, 1);
        check("reenter_cnt", {N_counter, M_counter}, 0);
        step(0, 1, 1, 5, 3);
        step(1, 1, 0, 0, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_N", N, 0);
        step(0, 0, 0, 0, 0);
        check("rst_pending_flushed", N, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 150) == 0, ($urandom % 25) != 0, ($urandom % 5) == 0,
                 $urandom_range(0, 7), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
